// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the LED sequence presenter: state codes, default timings, LED width.
// ONE_HOT_LEDS_EN selects 2-bit colour-index decoding of memory data instead of raw codes.
package exibe_sequencia_pkg;

    localparam int LED_W            = 4;
    localparam int T_ACESO_PADRAO   = 500;
    localparam int T_APAGADO_PADRAO = 250;

    // Codes double as the debug display value, so they are fixed explicitly.
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        ACESO   = 4'd3,
        APAGADO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    function automatic logic [LED_W-1:0] codifica_led(input logic [LED_W-1:0] dado);
`ifdef ONE_HOT_LEDS_EN
        return LED_W'(1) << dado[1:0];
`else
        return dado;
`endif
    endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Bus between the sequence presenter, its memory and the game control unit.
// master: control unit + memory side; slave: the presenter.
interface exibe_sequencia_if #(
    parameter int ADDR_W = 4
);
    import exibe_sequencia_pkg::*;

    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [ADDR_W-1:0] endereco;
    logic [LED_W-1:0]  dado;
    logic [LED_W-1:0]  leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, limite, dado,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, limite, dado,
        output endereco, leds, ocupado, pronto, db_estado
    );

endinterface

// File: rtl/contador_tempo.sv
// Modulo-M cycle counter: counts 0..M-1 while conta is high, fim flags the last count.
module contador_tempo #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int CW = $clog2(M) + 1;

    logic [CW-1:0] conta_q, conta_d;

    assign fim = (conta_q == CW'(M - 1));

    always_comb begin
        conta_d = conta_q;
        if (zera) begin
            conta_d = '0;
        end else if (conta) begin
            conta_d = fim ? '0 : conta_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

endmodule

// File: rtl/exibe_sequencia.sv
// Shows memory elements 0..limite on the LEDs (lit period, then blank gap) and pulses pronto.
// Build option ONE_HOT_LEDS_EN: memory holds a 2-bit colour index decoded to a one-hot LED.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int T_ACESO   = T_ACESO_PADRAO,
    parameter int T_APAGADO = T_APAGADO_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    exibe_sequencia_if.slave bus
);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              fim_aceso, fim_apagado;

    // One counter per period; each is held at zero outside its own state.
    contador_tempo #(.M(T_ACESO)) u_tempo_aceso (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q != ACESO),
        .conta (estado_q == ACESO),
        .fim   (fim_aceso)
    );

    contador_tempo #(.M(T_APAGADO)) u_tempo_apagado (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q != APAGADO),
        .conta (estado_q == APAGADO),
        .fim   (fim_apagado)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        leds_d     = leds_q;
        case (estado_q)
            OCIOSO: begin
                leds_d = '0;
                if (bus.iniciar) begin
                    estado_d   = BUSCA;
                    endereco_d = '0;
                    limite_d   = bus.limite;
                end
            end
            BUSCA:   estado_d = CARREGA;
            CARREGA: begin
                leds_d   = codifica_led(bus.dado);
                estado_d = ACESO;
            end
            ACESO: begin
                if (fim_aceso) begin
                    leds_d   = '0;
                    estado_d = APAGADO;
                end
            end
            APAGADO: begin
                if (fim_apagado) begin
                    // Compare before incrementing so the last address never wraps.
                    if (endereco_q == limite_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + ADDR_W'(1);
                        estado_d   = BUSCA;
                    end
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking updates so every register sees pre-edge values of the others.
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            limite_q   <= '0;
            leds_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            leds_q     <= leds_d;
        end
    end

    assign bus.endereco  = endereco_q;
    assign bus.leds      = leds_q;
    assign bus.ocupado   = (estado_q != OCIOSO);
    assign bus.pronto    = (estado_q == FIM);
    assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed, table-driven bench for exibe_sequencia with T_ACESO=4, T_APAGADO=2.
// Expected per-cycle outputs come from hand-built tables; multi-cycle corners are hand sequences.
module tb_exibe_sequencia;
    import exibe_sequencia_pkg::*;

    localparam int ADDR_W = 4;
    localparam int T_AC   = 4;
    localparam int T_AP   = 2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    exibe_sequencia_if #(.ADDR_W(ADDR_W)) bus ();

    exibe_sequencia #(
        .ADDR_W    (ADDR_W),
        .T_ACESO   (T_AC),
        .T_APAGADO (T_AP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read memory model: data valid one cycle after the address.
    logic [3:0] mem [16];
    always @(posedge clock) bus.dado <= mem[bus.endereco];

    typedef struct {
        logic [3:0] estado;
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       pronto;
    } vec_t;

    vec_t       tab [40];
    logic [3:0] lexp [3];
    logic [3:0] l15;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void put(int lo, int hi, logic [3:0] est, logic [3:0] ld, logic [3:0] ende, logic pr);
        for (int k = lo; k <= hi; k++) tab[k] = '{est, ld, ende, pr};
    endfunction

    // Row k holds the outputs expected right after edge E+k, E being the start edge.
    function automatic void fill(int n);
        for (int e = 0; e < n; e++) begin
            put(8*e,     8*e,     BUSCA,   4'h0,    4'(e), 1'b0);
            put(8*e + 1, 8*e + 1, CARREGA, 4'h0,    4'(e), 1'b0);
            put(8*e + 2, 8*e + 5, ACESO,   lexp[e], 4'(e), 1'b0);
            put(8*e + 6, 8*e + 7, APAGADO, 4'h0,    4'(e), 1'b0);
        end
        put(8*n,     8*n,     FIM,    4'h0, 4'(n - 1), 1'b1);
        put(8*n + 1, 8*n + 1, OCIOSO, 4'h0, 4'(n - 1), 1'b0);
    endfunction

    // modo 1: iniciar + limite=0 during element 1 ACESO; modo 2: iniciar during FIM.
    task automatic run_table(input int len, input int modo, input logic [3:0] lim, input string nome);
        for (int k = 0; k < len; k++) begin
            bus.iniciar = (k == 0);
            bus.limite  = lim;
            if (modo == 1 && k >= 11) begin
                bus.limite  = 4'd0;
                bus.iniciar = (k == 11);
            end
            if (modo == 2 && k == len - 1) bus.iniciar = 1'b1;
            tick();
            check($sformatf("%s[%0d].estado", nome, k),   bus.db_estado, tab[k].estado);
            check($sformatf("%s[%0d].leds", nome, k),     bus.leds,      tab[k].leds);
            check($sformatf("%s[%0d].endereco", nome, k), bus.endereco,  tab[k].endereco);
            check($sformatf("%s[%0d].pronto", nome, k),   bus.pronto,    tab[k].pronto);
            check($sformatf("%s[%0d].ocupado", nome, k),  bus.ocupado,   tab[k].estado != 4'd0);
        end
        bus.iniciar = 1'b0;
    endtask

    task automatic check_idle(input string nome);
        check({nome, ".estado"},   bus.db_estado, 4'd0);
        check({nome, ".leds"},     bus.leds,      4'h0);
        check({nome, ".endereco"}, bus.endereco,  4'h0);
        check({nome, ".pronto"},   bus.pronto,    1'b0);
        check({nome, ".ocupado"},  bus.ocupado,   1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
`ifdef ONE_HOT_LEDS_EN
        mem[0] = 4'b0010; mem[1] = 4'b0001; mem[2] = 4'b0011;
        lexp[0] = 4'b0100; lexp[1] = 4'b0010; lexp[2] = 4'b1000;
        l15 = 4'b1000;
`else
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
        lexp[0] = 4'b0001; lexp[1] = 4'b0100; lexp[2] = 4'b1000;
        l15 = 4'hF;
`endif
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.limite  = 4'd0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("idle");

        fill(3);
        run_table(26, 0, 4'd2, "full");
        tick();
        run_table(26, 1, 4'd2, "ignora");

        fill(1);
        run_table(10, 2, 4'd0, "unico");
        tick();
        check("unico.sem_reinicio", bus.db_estado, 4'd0);

        // Reset during APAGADO of element 0.
        bus.limite  = 4'd2;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("rst_apagado.pre", bus.db_estado, 4'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_apagado");
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rst_apagado.pos[%0d].pronto", k), bus.pronto, 1'b0);
            check($sformatf("rst_apagado.pos[%0d].estado", k), bus.db_estado, 4'd0);
        end

        // Reset while an element is lit must blank the LEDs.
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        tick();
        tick();
        check("rst_aceso.pre", bus.leds, lexp[0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_aceso");

        run_table(10, 0, 4'd0, "apos_reset");

        // limite at full range: every address shown, no wrap.
        bus.limite  = 4'd15;
        bus.iniciar = 1'b1;
        for (int k = 0; k <= 129; k++) begin
            tick();
            bus.iniciar = 1'b0;
            bus.limite  = 4'd3;
            if (k == 122) check("max.leds15", bus.leds, l15);
            if (k == 126) begin
                check("max.apagado.estado", bus.db_estado, 4'd4);
                check("max.apagado.endereco", bus.endereco, 4'd15);
            end
            if (k == 127) check("max.pre_fim.pronto", bus.pronto, 1'b0);
            if (k == 128) begin
                check("max.fim.estado", bus.db_estado, 4'd5);
                check("max.fim.pronto", bus.pronto, 1'b1);
                check("max.fim.endereco", bus.endereco, 4'd15);
            end
            if (k == 129) begin
                check("max.ocioso.estado", bus.db_estado, 4'd0);
                check("max.ocioso.endereco", bus.endereco, 4'd15);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
